// File: rtl/circuit3_driver.sv
// Stimulus driver and response checker for the 3-input test circuit.
// Steps {a,b,c} through 000..111, samples o after a settle time, and records mismatches.
module circuit3_driver #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [7:0]  EXPECTED      = 8'b0100_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_count,
  output logic [7:0] fail_mask,
  output logic [2:0] vec_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] mcount_q, mcount_d;
  logic [7:0] fmask_q, fmask_d;

  logic       exp_bit;
  logic       miss;
  logic [3:0] mcount_inc;

  assign exp_bit    = EXPECTED[vec_q];
  // Anything other than a clean match (including X/Z on o) is a mismatch.
  assign miss       = (o === exp_bit) ? 1'b0 : 1'b1;
  assign mcount_inc = mcount_q + {3'b000, miss};

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    mcount_d = mcount_q;
    fmask_d  = fmask_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          vec_d    = 3'd0;
          cnt_d    = CNT_RELOAD;
          pass_d   = 1'b0;
          mcount_d = 4'd0;
          fmask_d  = 8'h00;
        end
      end
      RUN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          mcount_d = mcount_inc;
          if (miss) fmask_d[vec_q] = 1'b1;
          if (vec_q != 3'd7) begin
            vec_d = vec_q + 3'd1;
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            pass_d  = (mcount_inc == 4'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= 3'd0;
      cnt_q    <= 8'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mcount_q <= 4'd0;
      fmask_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mcount_q <= mcount_d;
      fmask_q  <= fmask_d;
    end
  end

  // Stimulus is the vector index itself, so a/b/c hold their last value in IDLE.
  assign a              = vec_q[2];
  assign b              = vec_q[1];
  assign c              = vec_q[0];
  assign vec_idx        = vec_q;
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mcount_q;
  assign fail_mask      = fmask_q;

endmodule

// File: tb/tb_circuit3_driver.sv
// Bench for circuit3_driver: a truth-table circuit model feeds o; results are
// predicted from the XOR of that table against the expected table.
module tb_circuit3_driver;
  localparam int         S0  = 3;
  localparam logic [7:0] EXP = 8'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1;
  logic [7:0] tt0, tt1;
  logic       o0, o1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] mc0, mc1;
  logic [7:0] fm0, fm1;
  logic [2:0] v0, v1;

  // Circuit under test: o is looked up from a truth table on the driven vector.
  assign o0 = tt0[{a0, b0, c0}];
  assign o1 = tt1[{a1, b1, c1}];

  circuit3_driver #(.SETTLE_CYCLES(S0), .EXPECTED(EXP)) dut (
    .clk(clk), .rst(rst), .start(start0), .o(o0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_count(mc0), .fail_mask(fm0), .vec_idx(v0));

  circuit3_driver #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .o(o1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_count(mc1), .fail_mask(fm1), .vec_idx(v1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] tt;
    logic [7:0] mask;
    logic [3:0] cnt;
    logic       pass;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] snap0();
    return {busy0, done0, pass0, v0, a0, b0, c0, mc0, fm0};
  endfunction

  function automatic logic [20:0] want(input logic bsy, input logic dn, input logic ps,
                                       input logic [2:0] v, input logic [3:0] mc,
                                       input logic [7:0] fm);
    return {bsy, dn, ps, v, v, mc, fm};
  endfunction

  // One full run on the S=3 instance, checked every cycle. Caller sits just after a negedge.
  task automatic run0(input string nm, input logic [7:0] tt, input logic [7:0] mask,
                      input logic [3:0] cnt, input logic ps, input bit hold);
    int k;
    logic [7:0] seen;
    tt0    = tt;
    start0 = 1'b1;
    @(negedge clk);
    if (!hold) start0 = 1'b0;
    for (int n = 0; n <= 8 * S0; n++) begin
      if (n > 0) @(negedge clk);
      k    = n / S0;
      seen = mask & 8'((1 << k) - 1);
      if (n < 8 * S0)
        chk($sformatf("%s_n%0d", nm, n), 32'(snap0()),
            32'(want(1'b1, 1'b0, 1'b0, 3'(k), 4'($countones(seen)), seen)));
      else
        chk($sformatf("%s_end", nm), 32'(snap0()), 32'(want(1'b0, 1'b1, ps, 3'd7, cnt, mask)));
    end
    $display("run %s tt=%h mask=%h cnt=%0d pass=%0d", nm, tt, fm0, mc0, pass0);
  endtask

  initial begin
    int cyc;
    int dcount;
    logic [7:0] rtt, rmask;

    tbl[0] = '{"correct", 8'h40, 8'h00, 4'd0, 1'b1};
    tbl[1] = '{"stuck0",  8'h00, 8'h40, 4'd1, 1'b0};
    tbl[2] = '{"stuck1",  8'hFF, 8'hBF, 4'd7, 1'b0};
    tbl[3] = '{"v7high",  8'hC0, 8'h80, 4'd1, 1'b0};
    tbl[4] = '{"inv",     8'hBF, 8'hFF, 4'd8, 1'b0};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; tt0 = EXP; tt1 = EXP;
    repeat (2) @(negedge clk);
    chk("reset0", 32'(snap0()), 32'(want(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00)));
    chk("reset1", 32'({busy1, done1, pass1, v1, mc1, fm1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run0(tbl[i].name, tbl[i].tt, tbl[i].mask, tbl[i].cnt, tbl[i].pass, 1'b0);
      @(negedge clk);
      chk({tbl[i].name, "_hold"}, 32'(snap0()),
          32'(want(1'b0, 1'b0, tbl[i].pass, 3'd7, tbl[i].cnt, tbl[i].mask)));
    end

    // start held through the run: exactly one run, then an immediate re-arm.
    run0("holdstart", 8'h00, 8'h40, 4'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("rearm", 32'(snap0()), 32'(want(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00)));
    cyc = 0;
    repeat (3) begin @(negedge clk); start0 = ~start0; cyc++; end
    start0 = 1'b0;
    while (!done0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rearm_len", 32'(cyc), 32'(8 * S0));
    chk("rearm_res", 32'(snap0()), 32'(want(1'b0, 1'b1, 1'b0, 3'd7, 4'd1, 8'h40)));
    $display("run rearm len=%0d cnt=%0d", cyc, mc0);
    @(negedge clk);

    // Reset in the middle of vector 4.
    tt0 = 8'hFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4 * S0) @(negedge clk);
    chk("pre_rst_vec", 32'(v0), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", 32'(snap0()), 32'(want(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00)));
    dcount = 0;
    repeat (8 * S0 + 4) begin
      @(negedge clk);
      if (done0 || busy0) dcount++;
    end
    chk("rst_no_done", 32'(dcount), 32'd0);
    $display("run midreset abandoned activity=%0d", dcount);
    run0("after_rst", 8'h40, 8'h00, 4'd0, 1'b1, 1'b0);
    @(negedge clk);

    // rst wins over start.
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start0 = 1'b0;
    chk("rst_prio", 32'(snap0()), 32'(want(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00)));
    @(negedge clk);

    // Randomized circuits against the truth-table model.
    for (int i = 0; i < 12; i++) begin
      rtt   = 8'($urandom);
      rmask = rtt ^ EXP;
      run0($sformatf("rand%0d", i), rtt, rmask, 4'($countones(rmask)), (rmask == 8'h00), 1'b0);
      @(negedge clk);
    end

    // S=1: one cycle per vector, done 8 edges after start.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) @(negedge clk);
      chk($sformatf("s1_n%0d", n), 32'({busy1, done1, v1, a1, b1, c1}),
          32'({(n < 8), (n == 8), 3'((n < 8) ? n : 7), 3'((n < 8) ? n : 7)}));
    end
    chk("s1_result", 32'({pass1, mc1, fm1}), 32'({1'b1, 4'd0, 8'h00}));
    $display("run s1 pass=%0d cnt=%0d mask=%h", pass1, mc1, fm1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
